adc_scan_sequencer: RTL and testbench

Autonomous scan controller for the ADC/AMUX/PLL datapath behind the ADC APB wrapper. It steps through an enabled-channel mask, selects each AMUX input, waits a settling time, triggers a conversion and waits for completion. It then writes each result to a per-channel result port and repeats in single-shot or continuous mode. It sits between the APB register file (configuration, start/abort, results) and the ADC/AMUX control inputs.

---
 rtl/adc_ctrl_pkg.sv | 25 ++
 rtl/adc_next_ch_finder.sv | 34 +++
 rtl/adc_scan_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// adc_ctrl_pkg : shared encodings and defaults for the ADC scan controller
// Revision 1.0
// ============================================================================
package adc_ctrl_pkg;

  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Value of a channel mask with no channel enabled
  localparam int CH_MASK_NONE = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_TRIGGER  = 3'd3,
    ST_WAIT     = 3'd4,
    ST_STORE    = 3'd5,
    ST_INTERVAL = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adc_next_ch_finder.sv
`default_nettype none
// ============================================================================
// adc_next_ch_finder : lowest set channel and next set channel above cur_ch
// Revision 1.0
// ============================================================================
module adc_next_ch_finder #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              has_next,
  output logic [CH_W-1:0]   first_ch
);

  // Scanning downward leaves the lowest qualifying index as the final winner
  always_comb begin
    next_ch  = '0;
    has_next = 1'b0;
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_ch = CH_W'(i);
      end
      if (mask[i] && (i > int'(cur_ch))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// adc_scan_sequencer : steps the AMUX through enabled channels, runs one ADC
// conversion per channel and reports each result, single-shot or continuous.
// Revision 1.0
// ============================================================================
module adc_scan_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int CH_W           = 3,
  parameter int RES_W          = 16,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NUM_CH-1:0] cfg_ch_mask,
  input  logic              cfg_continuous,
  input  logic [15:0]       cfg_interval,
  input  logic              start,
  input  logic              abort,
  output logic [CH_W-1:0]   amux_sel,
  output logic              adc_trigger,
  input  logic              adc_done,
  input  logic [RES_W-1:0]  adc_data,
  output logic              res_we,
  output logic [CH_W-1:0]   res_ch,
  output logic [RES_W-1:0]  res_data,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err,
  output logic              irq
);

  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]    amux_sel_q, amux_sel_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [15:0]        int_cnt_q, int_cnt_d;
  logic               adc_trigger_q, adc_trigger_d;
  logic               res_we_q, res_we_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               busy_q, busy_d;
  logic               scan_done_q, scan_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic               irq_q, irq_d;

  logic [NUM_CH-1:0]  finder_mask;
  logic [CH_W-1:0]    next_ch, first_ch;
  logic               has_next;
  logic               live_mask_any;

  // Between scans the live mask seeds the first channel; during a scan the frozen copy drives advance
  assign finder_mask   = ((state_q == ST_IDLE) || (state_q == ST_INTERVAL)) ? cfg_ch_mask : mask_q;
  assign live_mask_any = (cfg_ch_mask != NUM_CH'(CH_MASK_NONE));

  adc_next_ch_finder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_finder (
    .mask     (finder_mask),
    .cur_ch   (cur_ch_q),
    .next_ch  (next_ch),
    .has_next (has_next),
    .first_ch (first_ch)
  );

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    cur_ch_d      = cur_ch_q;
    amux_sel_d    = amux_sel_q;
    settle_cnt_d  = settle_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    int_cnt_d     = int_cnt_q;
    adc_trigger_d = 1'b0;
    res_we_d      = 1'b0;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    irq_d         = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && live_mask_any) begin
            mask_d        = cfg_ch_mask;
            cur_ch_d      = first_ch;
            timeout_err_d = 1'b0;
            state_d       = ST_SELECT;
          end
        end
        ST_SELECT: begin
          amux_sel_d   = cur_ch_q;
          settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == '0) begin
            adc_trigger_d = 1'b1;
            tmo_cnt_d     = '0;
            state_d       = ST_TRIGGER;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        ST_TRIGGER: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // Result strobes are registered, so they are computed here to appear during STORE
          if (adc_done) begin
            res_we_d    = 1'b1;
            res_ch_d    = cur_ch_q;
            res_data_d  = adc_data;
            scan_done_d = !has_next;
            irq_d       = !has_next;
            state_d     = ST_STORE;
          end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_d = 1'b1;
            irq_d         = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
        ST_STORE: begin
          if (has_next) begin
            cur_ch_d = next_ch;
            state_d  = ST_SELECT;
          end else if (cfg_continuous) begin
            int_cnt_d = '0;
            state_d   = ST_INTERVAL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_INTERVAL: begin
          if (int_cnt_q == cfg_interval) begin
            if (live_mask_any) begin
              mask_d   = cfg_ch_mask;
              cur_ch_d = first_ch;
              state_d  = ST_SELECT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            int_cnt_d = int_cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      cur_ch_q      <= '0;
      amux_sel_q    <= '0;
      settle_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      int_cnt_q     <= '0;
      adc_trigger_q <= 1'b0;
      res_we_q      <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      busy_q        <= 1'b0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      cur_ch_q      <= cur_ch_d;
      amux_sel_q    <= amux_sel_d;
      settle_cnt_q  <= settle_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      int_cnt_q     <= int_cnt_d;
      adc_trigger_q <= adc_trigger_d;
      res_we_q      <= res_we_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      busy_q        <= busy_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
      irq_q         <= irq_d;
    end
  end

  assign amux_sel    = amux_sel_q;
  assign adc_trigger = adc_trigger_q;
  assign res_we      = res_we_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign scan_done   = scan_done_q;
  assign timeout_err = timeout_err_q;
  assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// tb_adc_scan_sequencer : directed stimulus with a result scoreboard
// Revision 1.0
// ============================================================================
module tb_adc_scan_sequencer;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int RES_W  = 16;
  localparam int SETTLE = 16;
  localparam int TMO    = 1024;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [NUM_CH-1:0] cfg_ch_mask = '0;
  logic              cfg_continuous = 1'b0;
  logic [15:0]       cfg_interval = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CH_W-1:0]   amux_sel;
  logic              adc_trigger;
  logic              adc_done = 1'b0;
  logic [RES_W-1:0]  adc_data = '0;
  logic              res_we;
  logic [CH_W-1:0]   res_ch;
  logic [RES_W-1:0]  res_data;
  logic              busy;
  logic              scan_done;
  logic              timeout_err;
  logic              irq;

  adc_scan_sequencer #(
    .NUM_CH         (NUM_CH),
    .CH_W           (CH_W),
    .RES_W          (RES_W),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .cfg_ch_mask    (cfg_ch_mask),
    .cfg_continuous (cfg_continuous),
    .cfg_interval   (cfg_interval),
    .start          (start),
    .abort          (abort),
    .amux_sel       (amux_sel),
    .adc_trigger    (adc_trigger),
    .adc_done       (adc_done),
    .adc_data       (adc_data),
    .res_we         (res_we),
    .res_ch         (res_ch),
    .res_data       (res_data),
    .busy           (busy),
    .scan_done      (scan_done),
    .timeout_err    (timeout_err),
    .irq            (irq)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_trig = 0, n_we = 0, n_done = 0, n_irq = 0;
  logic [CH_W+RES_W-1:0] exp_q[$];
  logic [CH_W+RES_W-1:0] mon_exp;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every result write and tallies pulses
  always @(negedge PCLK) begin
    if (adc_trigger) n_trig++;
    if (irq) n_irq++;
    if (scan_done) begin
      n_done++;
      chk("irq_with_scan_done", 32'(irq), 32'd1);
    end
    if (res_we) begin
      n_we++;
      if (exp_q.size() == 0) begin
        chk("unexpected_res_we", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("res_ch", 32'(res_ch), 32'(mon_exp[CH_W+RES_W-1:RES_W]));
        chk("res_data", 32'(res_data), 32'(mon_exp[RES_W-1:0]));
      end
    end
  end

  task automatic pulse_start(output int at);
    @(negedge PCLK);
    start = 1'b1;
    at = cyc;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  task automatic wait_trig(output int at, output logic [CH_W-1:0] ch);
    at = -1;
    ch = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (adc_trigger) begin
        at = cyc;
        ch = amux_sel;
        return;
      end
    end
    chk("trigger_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic give_done(input logic [RES_W-1:0] data, input logic [CH_W-1:0] ch);
    @(negedge PCLK);
    adc_done = 1'b1;
    adc_data = data;
    exp_q.push_back({ch, data});
    @(negedge PCLK);
    adc_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_amux_sel"}, 32'(amux_sel), 32'd0);
    chk({tag, "_adc_trigger"}, 32'(adc_trigger), 32'd0);
    chk({tag, "_res_we"}, 32'(res_we), 32'd0);
    chk({tag, "_res_ch"}, 32'(res_ch), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t, t1, t2, t3, d_trig, d_we, d_done, d_irq;
    logic [CH_W-1:0] ch;
    logic seen;

    repeat (3) @(negedge PCLK);
    chk_reset_outputs("reset");
    PRESET = 1'b0;
    @(negedge PCLK);

    // Single-shot two-channel scan
    cfg_ch_mask = 8'b0000_0101;
    d_we = n_we; d_done = n_done; d_irq = n_irq;
    pulse_start(s);
    wait_trig(t, ch);
    chk("first_trigger_latency", 32'(t - s), 32'(SETTLE + 2));
    chk("first_trigger_ch", 32'(ch), 32'd0);
    give_done(16'h1234, 3'd0);
    wait_trig(t, ch);
    chk("second_trigger_ch", 32'(ch), 32'd2);
    give_done(16'hBEEF, 3'd2);
    repeat (3) @(negedge PCLK);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_scan_done_count", 32'(n_done - d_done), 32'd1);
    chk("single_irq_count", 32'(n_irq - d_irq), 32'd1);
    chk("single_we_count", 32'(n_we - d_we), 32'd2);

    // Empty mask: start ignored
    cfg_ch_mask = 8'h00;
    d_trig = n_trig; d_done = n_done;
    seen = 1'b0;
    pulse_start(s);
    for (int i = 0; i < 25; i++) begin
      @(negedge PCLK);
      if (busy) seen = 1'b1;
    end
    chk("empty_mask_busy_seen", 32'(seen), 32'd0);
    chk("empty_mask_triggers", 32'(n_trig - d_trig), 32'd0);
    chk("empty_mask_scan_done", 32'(n_done - d_done), 32'd0);

    // Continuous mode, period and mask reload at the scan boundary
    cfg_ch_mask = 8'h80;
    cfg_continuous = 1'b1;
    cfg_interval = 16'd10;
    d_done = n_done;
    pulse_start(s);
    wait_trig(t1, ch);
    chk("cont_scan1_ch", 32'(ch), 32'd7);
    give_done(16'h0077, 3'd7);
    wait_trig(t2, ch);
    chk("cont_period_1", 32'(t2 - t1), 32'(SETTLE + 15));
    chk("cont_scan2_ch", 32'(ch), 32'd7);
    cfg_ch_mask = 8'h01;
    give_done(16'h0707, 3'd7);
    wait_trig(t3, ch);
    chk("cont_period_2", 32'(t3 - t2), 32'(SETTLE + 15));
    chk("cont_scan3_ch", 32'(ch), 32'd0);
    give_done(16'h0101, 3'd0);
    cfg_continuous = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("cont_busy_after", 32'(busy), 32'd0);
    chk("cont_scan_done_count", 32'(n_done - d_done), 32'd3);

    // Conversion timeout
    cfg_ch_mask = 8'h02;
    d_we = n_we; d_irq = n_irq;
    pulse_start(s);
    wait_trig(t, ch);
    t1 = -1;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge PCLK);
      if (timeout_err) begin
        t1 = cyc;
        break;
      end
    end
    chk("timeout_latency", 32'(t1 - t), 32'(TMO + 1));
    chk("timeout_irq", 32'(irq), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    @(negedge PCLK);
    chk("timeout_irq_single", 32'(irq), 32'd0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    chk("timeout_irq_count", 32'(n_irq - d_irq), 32'd1);
    chk("timeout_no_we", 32'(n_we - d_we), 32'd0);

    // Restart clears the error; abort during SETTLE
    d_trig = n_trig; d_done = n_done; d_we = n_we;
    pulse_start(s);
    chk("restart_clears_timeout", 32'(timeout_err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge PCLK);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    chk("abort_settle_busy", 32'(busy), 32'd0);
    repeat (30) @(negedge PCLK);
    chk("abort_settle_triggers", 32'(n_trig - d_trig), 32'd0);
    chk("abort_settle_scan_done", 32'(n_done - d_done), 32'd0);
    chk("abort_settle_we", 32'(n_we - d_we), 32'd0);

    // Abort during WAIT coinciding with adc_done
    cfg_ch_mask = 8'h01;
    d_we = n_we; d_done = n_done;
    pulse_start(s);
    wait_trig(t, ch);
    @(negedge PCLK);
    abort = 1'b1;
    adc_done = 1'b1;
    adc_data = 16'hDEAD;
    @(negedge PCLK);
    abort = 1'b0;
    adc_done = 1'b0;
    chk("abort_wait_busy", 32'(busy), 32'd0);
    chk("abort_wait_res_we", 32'(res_we), 32'd0);
    repeat (5) @(negedge PCLK);
    chk("abort_wait_we_count", 32'(n_we - d_we), 32'd0);
    chk("abort_wait_scan_done", 32'(n_done - d_done), 32'd0);

    // Stray done in IDLE, stray done plus start during SETTLE, then reset mid-WAIT
    d_we = n_we;
    @(negedge PCLK);
    adc_done = 1'b1;
    @(negedge PCLK);
    adc_done = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge PCLK);
    chk("stray_idle_we", 32'(n_we - d_we), 32'd0);
    cfg_ch_mask = 8'h03;
    pulse_start(s);
    repeat (4) @(negedge PCLK);
    adc_done = 1'b1;
    start = 1'b1;
    @(negedge PCLK);
    adc_done = 1'b0;
    start = 1'b0;
    wait_trig(t, ch);
    chk("stray_settle_latency", 32'(t - s), 32'(SETTLE + 2));
    chk("stray_settle_ch", 32'(ch), 32'd0);
    give_done(16'h5555, 3'd0);
    wait_trig(t, ch);
    chk("reset_scan_ch", 32'(ch), 32'd1);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk_reset_outputs("preset_mid_wait");
    d_we = n_we;
    repeat (5) @(negedge PCLK);
    chk("preset_no_we", 32'(n_we - d_we), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
